// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC / branch prediction slice.
//  - 2-bit bimodal counter encodings and a saturating update helper
//  - instruction size and word-offset shift used by next-PC arithmetic
package pc_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,   // strongly not taken
      WNT = 2'b01,   // weakly not taken (reset value)
      WT  = 2'b10,   // weakly taken (allocation value)
      ST  = 2'b11    // strongly taken
   } ctr_e;

   localparam int INSTR_BYTES = 4;
   localparam int WORD_SHIFT  = 2;

   // Saturating bimodal counter step: up on taken, down on not taken.
   function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = cur + 2'b01;
      end else begin
         if (cur != SNT) nxt = cur - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Bus between the fetch PC unit and its surroundings (pipeline control,
// Execute stage, fetch consumers).
//  slave  : the pc_predict_unit itself
//  master : whoever drives Stall / Execute results and consumes fetch outputs
// There is no valid/ready handshake here: ExValid simply qualifies the Ex*
// fields in the cycle it is high; Flush is a same-cycle combinational answer.
interface pc_predict_unit_if #(
   parameter int PC_W   = 64,
   parameter int PERF_W = 32
);
   logic              Stall;
   logic [PC_W-1:0]   FetchPC;
   logic [PC_W-1:0]   FetchPredNextPC;
   logic              FetchPredTaken;
   logic              ExValid;
   logic [PC_W-1:0]   ExPC;
   logic [PC_W-1:0]   ExSignExtImm;
   logic              ExBranch;
   logic              ExInvertZero;
   logic              ExALUZero;
   logic              ExUncondbranch;
   logic              ExRegJump;
   logic [PC_W-1:0]   ExRegTarget;
   logic [PC_W-1:0]   ExPredNextPC;
   logic              Flush;
   logic [PERF_W-1:0] PerfMispredicts;

   modport master (
      output Stall, ExValid, ExPC, ExSignExtImm, ExBranch, ExInvertZero,
             ExALUZero, ExUncondbranch, ExRegJump, ExRegTarget, ExPredNextPC,
      input  FetchPC, FetchPredNextPC, FetchPredTaken, Flush, PerfMispredicts
   );

   modport slave (
      input  Stall, ExValid, ExPC, ExSignExtImm, ExBranch, ExInvertZero,
             ExALUZero, ExUncondbranch, ExRegJump, ExRegTarget, ExPredNextPC,
      output FetchPC, FetchPredNextPC, FetchPredTaken, Flush, PerfMispredicts
   );
endinterface

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped branch target buffer storage.
//  clk, rst                     : clock, synchronous active-high reset
//  rd_idx/rd_tag -> rd_hit, rd_ctr, rd_tgt : asynchronous prediction lookup
//  upd_en, upd_idx, upd_tag, upd_taken, upd_tgt : resolved control-flow
//     outcome, applied on the clock edge (counter train / allocate)
// The read port sees pre-edge contents, so a same-cycle update to the
// looked-up index only becomes visible on the following cycle.
module btb_table
   import pc_pkg::*;
#(
   parameter int PC_W  = 64,
   parameter int IDX_W = 4,
   parameter int TAG_W = PC_W - IDX_W - 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_hit,
   output logic [1:0]       rd_ctr,
   output logic [PC_W-1:0]  rd_tgt,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_tgt
);
   localparam int DEPTH = 1 << IDX_W;

   logic             valid_q [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [PC_W-1:0]  tgt_q   [DEPTH];
   logic [1:0]       ctr_q   [DEPTH];

   logic             upd_hit;
   logic             wr_en_d;
   logic [1:0]       wr_ctr_d;
   logic [PC_W-1:0]  wr_tgt_d;

   always_comb begin
      rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      rd_ctr = ctr_q[rd_idx];
      rd_tgt = tgt_q[rd_idx];
   end

   // Hits train the counter; misses only allocate when taken (a not-taken
   // miss would just waste the slot on a fall-through).
   always_comb begin
      upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      wr_en_d  = upd_en && (upd_hit || upd_taken);
      wr_ctr_d = upd_hit ? ctr_next(ctr_q[upd_idx], upd_taken) : WT;
      wr_tgt_d = upd_taken ? upd_tgt : tgt_q[upd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= WNT;
         end
      end else if (wr_en_d) begin
         valid_q[upd_idx] <= 1'b1;
         tag_q[upd_idx]   <= upd_tag;
         tgt_q[upd_idx]   <= wr_tgt_d;
         ctr_q[upd_idx]   <= wr_ctr_d;
      end
   end
endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage program counter with BTB + bimodal prediction.
//  CLK, Reset : clock, synchronous active-high reset
//  bus (slave): Stall in; FetchPC / FetchPredNextPC / FetchPredTaken out;
//               Execute resolution (ExValid, ExPC, ExSignExtImm, ExBranch,
//               ExInvertZero, ExALUZero, ExUncondbranch, ExRegJump,
//               ExRegTarget, ExPredNextPC) in; Flush and PerfMispredicts out.
// Execute compares the real next PC against the prediction that travelled
// with the instruction; any difference flushes and redirects, which also
// covers non-control instructions that aliased onto a BTB entry.
module pc_predict_unit
   import pc_pkg::*;
#(
   parameter int              PC_W      = 64,
   parameter int              BTB_DEPTH = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              PERF_W    = 32
)(
   input  logic              CLK,
   input  logic              Reset,
   pc_predict_unit_if.slave  bus
);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = PC_W - IDX_W - WORD_SHIFT;

   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PERF_W-1:0] perf_q, perf_d;

   logic              btb_hit;
   logic [1:0]        btb_ctr;
   logic [PC_W-1:0]   btb_tgt;
   logic              pred_taken;
   logic [PC_W-1:0]   pred_next;

   logic              ex_ctl;
   logic              ex_taken;
   logic [PC_W-1:0]   ex_target;
   logic [PC_W-1:0]   ex_actual;
   logic              flush;

   btb_table #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_btb (
      .clk       (CLK),
      .rst       (Reset),
      .rd_idx    (fetch_pc_q[IDX_W+1:2]),
      .rd_tag    (fetch_pc_q[PC_W-1:IDX_W+2]),
      .rd_hit    (btb_hit),
      .rd_ctr    (btb_ctr),
      .rd_tgt    (btb_tgt),
      .upd_en    (bus.ExValid & ex_ctl),
      .upd_idx   (bus.ExPC[IDX_W+1:2]),
      .upd_tag   (bus.ExPC[PC_W-1:IDX_W+2]),
      .upd_taken (ex_taken),
      .upd_tgt   (ex_target)
   );

   // Prediction: taken only when the entry matches and the counter MSB is set.
   always_comb begin
      pred_taken = btb_hit & btb_ctr[1];
      pred_next  = pred_taken ? btb_tgt : fetch_pc_q + PC_W'(INSTR_BYTES);
   end

   // Resolution of the instruction in Execute (all arithmetic wraps).
   always_comb begin
      ex_ctl    = bus.ExBranch | bus.ExUncondbranch | bus.ExRegJump;
      ex_taken  = bus.ExUncondbranch | bus.ExRegJump |
                  (bus.ExBranch & (bus.ExALUZero ^ bus.ExInvertZero));
      ex_target = bus.ExRegJump ? bus.ExRegTarget
                                : bus.ExPC + (bus.ExSignExtImm << WORD_SHIFT);
      ex_actual = ex_taken ? ex_target : bus.ExPC + PC_W'(INSTR_BYTES);
      flush     = bus.ExValid & ~Reset & (ex_actual != bus.ExPredNextPC);
   end

   // Redirect beats Stall: the stalled fetch is being killed anyway.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (Reset)          fetch_pc_d = RESET_PC;
      else if (flush)     fetch_pc_d = ex_actual;
      else if (!bus.Stall) fetch_pc_d = pred_next;

      perf_d = perf_q;
      if (Reset)                     perf_d = '0;
      else if (flush && perf_q != '1) perf_d = perf_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      fetch_pc_q <= fetch_pc_d;
      perf_q     <= perf_d;
   end

   assign bus.FetchPC         = fetch_pc_q;
   assign bus.FetchPredNextPC = pred_next;
   assign bus.FetchPredTaken  = pred_taken;
   assign bus.Flush           = flush;
   assign bus.PerfMispredicts = perf_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios followed by random Execute
// traffic, every cycle compared against a behavioural model of the fetch PC,
// BTB contents and mispredict counter.
module tb_pc_predict_unit;
   localparam int PC_W   = 64;
   localparam int DEPTH  = 16;
   localparam int PERF_W = 4;
   localparam int PERF_MAX = (1 << PERF_W) - 1;

   logic CLK;
   logic Reset;

   pc_predict_unit_if #(.PC_W(PC_W), .PERF_W(PERF_W)) bus ();

   pc_predict_unit #(
      .PC_W      (PC_W),
      .BTB_DEPTH (DEPTH),
      .RESET_PC  (64'h0),
      .PERF_W    (PERF_W)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard / checker ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          v;
      logic [63:0] tag;
      logic [63:0] tgt;
      int          ctr;
   } ent_t;

   ent_t        m_btb [DEPTH];
   logic [63:0] m_pc;
   int          m_perf;

   function automatic int m_idx(input logic [63:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic bit m_hit(input logic [63:0] pc);
      return m_btb[m_idx(pc)].v && (m_btb[m_idx(pc)].tag == pc / (4 * DEPTH));
   endfunction

   function automatic bit m_taken(input logic [63:0] pc);
      return m_hit(pc) && (m_btb[m_idx(pc)].ctr >= 2);
   endfunction

   function automatic logic [63:0] m_next(input logic [63:0] pc);
      return m_taken(pc) ? m_btb[m_idx(pc)].tgt : pc + 64'd4;
   endfunction

   function automatic bit ex_is_taken();
      return bus.ExUncondbranch || bus.ExRegJump ||
             (bus.ExBranch && (bus.ExALUZero != bus.ExInvertZero));
   endfunction

   function automatic logic [63:0] ex_target();
      return bus.ExRegJump ? bus.ExRegTarget : bus.ExPC + bus.ExSignExtImm * 64'd4;
   endfunction

   function automatic logic [63:0] ex_actual();
      return ex_is_taken() ? ex_target() : bus.ExPC + 64'd4;
   endfunction

   function automatic bit m_flush();
      return bus.ExValid && !Reset && (ex_actual() != bus.ExPredNextPC);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_btb[i].v   = 1'b0;
         m_btb[i].tag = '0;
         m_btb[i].tgt = '0;
         m_btb[i].ctr = 1;
      end
      m_pc   = 64'h0;
      m_perf = 0;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic m_edge();
      bit          fl;
      logic [63:0] nxt;
      int          i;
      fl  = m_flush();
      nxt = m_next(m_pc);
      if (Reset) begin
         m_reset();
      end else begin
         if (bus.ExValid && (bus.ExBranch || bus.ExUncondbranch || bus.ExRegJump)) begin
            i = m_idx(bus.ExPC);
            if (m_hit(bus.ExPC)) begin
               if (ex_is_taken()) begin
                  m_btb[i].ctr = (m_btb[i].ctr < 3) ? m_btb[i].ctr + 1 : 3;
                  m_btb[i].tgt = ex_target();
               end else begin
                  m_btb[i].ctr = (m_btb[i].ctr > 0) ? m_btb[i].ctr - 1 : 0;
               end
            end else if (ex_is_taken()) begin
               m_btb[i].v   = 1'b1;
               m_btb[i].tag = bus.ExPC / (4 * DEPTH);
               m_btb[i].tgt = ex_target();
               m_btb[i].ctr = 2;
            end
         end
         if (fl)              m_pc = ex_actual();
         else if (!bus.Stall) m_pc = nxt;
         if (fl && m_perf < PERF_MAX) m_perf = m_perf + 1;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic set_idle();
      bus.Stall          = 1'b0;
      bus.ExValid        = 1'b0;
      bus.ExPC           = '0;
      bus.ExSignExtImm   = '0;
      bus.ExBranch       = 1'b0;
      bus.ExInvertZero   = 1'b0;
      bus.ExALUZero      = 1'b0;
      bus.ExUncondbranch = 1'b0;
      bus.ExRegJump      = 1'b0;
      bus.ExRegTarget    = '0;
      bus.ExPredNextPC   = '0;
   endtask

   task automatic ex_instr(input logic [63:0] pc, input logic [63:0] imm,
                           input bit br, input bit inv, input bit z,
                           input bit unc, input bit rj,
                           input logic [63:0] rt, input logic [63:0] pred);
      bus.ExValid        = 1'b1;
      bus.ExPC           = pc;
      bus.ExSignExtImm   = imm;
      bus.ExBranch       = br;
      bus.ExInvertZero   = inv;
      bus.ExALUZero      = z;
      bus.ExUncondbranch = unc;
      bus.ExRegJump      = rj;
      bus.ExRegTarget    = rt;
      bus.ExPredNextPC   = pred;
   endtask

   // Force fetch to a given PC via a non-control instruction whose carried
   // prediction is deliberately wrong.
   task automatic redirect_to(input logic [63:0] pc);
      ex_instr(pc - 64'd4, '0, 0, 0, 0, 0, 0, '0, pc + 64'd100);
   endtask

   // One clock: compare outputs mid-cycle, step the model, cross the edge.
   task automatic cycle();
      @(negedge CLK);
      chk("fetch_pc",   bus.FetchPC,                  m_pc);
      chk("pred_next",  bus.FetchPredNextPC,          m_next(m_pc));
      chk("pred_taken", 64'(bus.FetchPredTaken),      64'(m_taken(m_pc)));
      chk("flush",      64'(bus.Flush),               64'(m_flush()));
      chk("perf",       64'(bus.PerfMispredicts),     64'(m_perf));
      m_edge();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cls;
      int          s;
      logic [63:0] pc;
      logic [63:0] pred;

      set_idle();
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      m_reset();
      cycle();
      Reset = 1'b0;

      // 1. free-running sequential fetch
      repeat (3) cycle();
      chk("t1_pc12", bus.FetchPC, 64'hC);
      chk("t1_flush0", 64'(bus.Flush), 64'h0);
      chk("t1_perf0", 64'(bus.PerfMispredicts), 64'h0);

      // 2. B at 0x10, +4 words, predicted fall-through
      ex_instr(64'h10, 64'd4, 0, 0, 0, 1, 0, '0, 64'h14);
      cycle();
      chk("t2_redirect", bus.FetchPC, 64'h20);
      redirect_to(64'h10);
      cycle();
      set_idle();
      #1;
      chk("t2_refetch_next", bus.FetchPredNextPC, 64'h20);
      chk("t2_refetch_taken", 64'(bus.FetchPredTaken), 64'h1);
      cycle();

      // 3. CBNZ at 0x40, imm -2, taken, then not taken
      ex_instr(64'h40, -64'sd2, 1, 1, 0, 0, 0, '0, 64'h44);
      cycle();
      chk("t3_cbnz_target", bus.FetchPC, 64'h38);
      ex_instr(64'h40, -64'sd2, 1, 1, 1, 0, 0, '0, 64'h38);
      cycle();
      redirect_to(64'h40);
      cycle();
      set_idle();
      #1;
      chk("t3_weak_nt_next", bus.FetchPredNextPC, 64'h44);
      chk("t3_weak_nt_taken", 64'(bus.FetchPredTaken), 64'h0);
      cycle();

      // 4. stall vs. redirect, then plain stall
      redirect_to(64'h104);
      bus.Stall = 1'b1;
      cycle();
      chk("t4_flush_beats_stall", bus.FetchPC, 64'h104);
      set_idle();
      bus.Stall = 1'b1;
      repeat (3) cycle();
      chk("t4_stall_hold", bus.FetchPC, 64'h104);
      bus.Stall = 1'b0;

      // 5. BR to 0x1000, BTB target, then PC wrap
      ex_instr(64'h80, '0, 0, 0, 0, 0, 1, 64'h1000, 64'h84);
      cycle();
      chk("t5_br_redirect", bus.FetchPC, 64'h1000);
      redirect_to(64'h80);
      cycle();
      set_idle();
      #1;
      chk("t5_btb_tgt", bus.FetchPredNextPC, 64'h1000);
      redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
      cycle();
      chk("t5_top_pc", bus.FetchPC, 64'hFFFF_FFFF_FFFF_FFFC);
      set_idle();
      cycle();
      chk("t5_wrap", bus.FetchPC, 64'h0);

      // 6. Reset in a flush cycle discards the update and the count
      ex_instr(64'h10, 64'd4, 0, 0, 0, 1, 0, '0, 64'h14);
      Reset = 1'b1;
      @(negedge CLK);
      chk("t6_no_flush_in_reset", 64'(bus.Flush), 64'h0);
      @(posedge CLK);
      #1;
      m_reset();
      Reset = 1'b0;
      set_idle();
      chk("t6_pc_reset", bus.FetchPC, 64'h0);
      chk("t6_perf_reset", 64'(bus.PerfMispredicts), 64'h0);
      repeat (4) cycle();
      chk("t6_btb_cleared", 64'(bus.FetchPredTaken), 64'h0);

      // perf counter saturation
      repeat (PERF_MAX + 5) begin
         redirect_to(64'h200);
         cycle();
      end
      chk("t6_perf_sat", 64'(bus.PerfMispredicts), 64'(PERF_MAX));
      cycle();
      chk("t6_perf_hold", 64'(bus.PerfMispredicts), 64'(PERF_MAX));

      // random traffic; short reset so the counter can move again
      Reset = 1'b1;
      set_idle();
      cycle();
      Reset = 1'b0;
      repeat (2000) begin
         set_idle();
         Reset     = ($urandom_range(0, 63) == 0);
         bus.Stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) != 0) begin
            pc  = 64'($urandom_range(0, 255)) * 64'd4;
            cls = $urandom_range(0, 4);
            s   = $urandom_range(0, 31) - 16;
            case ($urandom_range(0, 3))
               0:       pred = pc + 64'd4;
               3:       pred = 64'($urandom_range(0, 255)) * 64'd4;
               default: pred = m_next(pc);
            endcase
            ex_instr(pc, 64'(s), cls == 1 || cls == 2, cls == 2,
                     1'($urandom_range(0, 1)), cls == 3, cls == 4,
                     64'($urandom_range(0, 255)) * 64'd4, pred);
            bus.ExValid = 1'b1;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
